ex_divider: RTL and testbench

- Multi-cycle integer divider in the EX stage, downstream of the ID/EX pipeline register.
- Consumes the DIV/DIVU operands (rs, rt) latched by ID/EX.
- Raises a stall request that the stall controller drives back as the EX stall bit, so the instruction holds in EX while the divider iterates.
- Produces quotient (to LO) and remainder (to HI) for the HI/LO write in the following stage.

---
 rtl/ex_divider_pkg.sv | 25 ++
 rtl/ex_divider_if.sv | 31 +++
 rtl/ex_divider_div_sign_fix.sv | 42 ++++
 rtl/ex_divider.sv | 157 +++++++++++++++
 tb/tb_ex_divider.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/ex_divider_pkg.sv
// ex_divider_pkg: shared constants and types for the EX-stage divider.
//   DIV_WIDTH     default operand/result width
//   RST_ENABLE    active level of the synchronous reset
//   ALUOP_DIV(U)  aluop codes that launch the divider
//   div_state_e   divider FSM state encoding
package ex_divider_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam logic        RST_ENABLE = 1'b1;

  localparam logic [7:0] ALUOP_DIV  = 8'b0001_1010;
  localparam logic [7:0] ALUOP_DIVU = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Decode helper for the ID/EX side: is this aluop a divide.
  function automatic logic is_div_aluop(input logic [7:0] aluop);
    return (aluop == ALUOP_DIV) || (aluop == ALUOP_DIVU);
  endfunction

endpackage

// File: rtl/ex_divider_if.sv
// ex_divider_if: EX-stage <-> divider handshake and result bus.
//   master: pipeline side (drives exception/start/signed_div/operands/accept)
//   slave : divider side (drives stall_req/done/quotient/remainder)
interface ex_divider_if
  import ex_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);

  logic             exception;
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             accept;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output exception, start, signed_div, dividend, divisor, accept,
    input  stall_req, done, quotient, remainder
  );

  modport slave (
    input  exception, start, signed_div, dividend, divisor, accept,
    output stall_req, done, quotient, remainder
  );

endinterface

// File: rtl/ex_divider_div_sign_fix.sv
// div_sign_fix: combinational sign handling around the unsigned divider core.
//   Pre-launch : abs_dividend_c/abs_divisor_c = operand magnitudes (raw for DIVU).
//   Post-CALC  : quotient_c/remainder_c = sign-corrected raw results, with the
//                divide-by-zero override (q = all ones, r = original dividend).
module div_sign_fix
  import ex_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] abs_dividend_c,
  output logic [WIDTH-1:0] abs_divisor_c,
  input  logic [WIDTH-1:0] raw_quo,
  input  logic [WIDTH-1:0] raw_rem,
  input  logic             quo_neg,
  input  logic             rem_neg,
  input  logic             div_zero,
  input  logic [WIDTH-1:0] orig_dividend,
  output logic [WIDTH-1:0] quotient_c,
  output logic [WIDTH-1:0] remainder_c
);

  // Two's complement negate, modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  assign abs_dividend_c = (signed_div && dividend[WIDTH-1]) ? neg(dividend) : dividend;
  assign abs_divisor_c  = (signed_div && divisor[WIDTH-1])  ? neg(divisor)  : divisor;

  always_comb begin
    quotient_c  = quo_neg ? neg(raw_quo) : raw_quo;
    remainder_c = rem_neg ? neg(raw_rem) : raw_rem;
    if (div_zero) begin
      quotient_c  = '1;
      remainder_c = orig_dividend;
    end
  end

endmodule

// File: rtl/ex_divider.sv
// ex_divider: multi-cycle restoring radix-2 divider for the EX stage.
//   clk, rst (sync, active-high)
//   bus (ex_divider_if.slave): exception, start, signed_div, dividend, divisor,
//     accept in; stall_req (combinational), done, quotient (LO), remainder (HI) out.
// Optional: define DIV_EARLY_OUT_EN to finish in one cycle when divisor is zero
// or |dividend| < |divisor|.
module ex_divider
  import ex_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  ex_divider_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd_sh;     // dividend bits shift out MSB-first, quotient bits shift in
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] orig_dvd;
  logic             quo_neg;
  logic             rem_neg;
  logic             div_zero;
  logic             done_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;

  logic [WIDTH-1:0] abs_dvd_c;
  logic [WIDTH-1:0] abs_dvs_c;
  logic [WIDTH-1:0] fix_quo_c;
  logic [WIDTH-1:0] fix_rem_c;

  // One restoring step; partial carries an extra bit so large unsigned
  // divisors (MSB set) never lose the remainder's top bit.
  logic [WIDTH:0]   partial_c;
  logic [WIDTH:0]   diff_c;
  logic             fits_c;
  logic [WIDTH-1:0] rem_nxt_c;
  logic [WIDTH-1:0] quo_nxt_c;

  assign partial_c = {rem_q, dvd_sh[WIDTH-1]};
  assign diff_c    = partial_c - {1'b0, dvs_mag};
  assign fits_c    = ~diff_c[WIDTH];
  assign rem_nxt_c = fits_c ? diff_c[WIDTH-1:0] : partial_c[WIDTH-1:0];
  assign quo_nxt_c = {dvd_sh[WIDTH-2:0], fits_c};

  div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .signed_div     (bus.signed_div),
    .dividend       (bus.dividend),
    .divisor        (bus.divisor),
    .abs_dividend_c (abs_dvd_c),
    .abs_divisor_c  (abs_dvs_c),
    .raw_quo        (quo_nxt_c),
    .raw_rem        (rem_nxt_c),
    .quo_neg        (quo_neg),
    .rem_neg        (rem_neg),
    .div_zero       (div_zero),
    .orig_dividend  (orig_dvd),
    .quotient_c     (fix_quo_c),
    .remainder_c    (fix_rem_c)
  );

`ifdef DIV_EARLY_OUT_EN
  logic early_c;
  assign early_c = (bus.divisor == '0) || (abs_dvd_c < abs_dvs_c);
`endif

  // Held high from the cycle start is first seen so the instruction never leaves EX early.
  assign bus.stall_req = (rst != RST_ENABLE) &&
                         (((state == DIV_IDLE) && bus.start && !bus.exception) ||
                          (state == DIV_CALC));

  assign bus.done      = done_r;
  assign bus.quotient  = quo_r;
  assign bus.remainder = rem_r;

  // FSM, iteration counter and shift/subtract datapath.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      dvd_sh   <= '0;
      dvs_mag  <= '0;
      rem_q    <= '0;
      orig_dvd <= '0;
      quo_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      done_r   <= 1'b0;
      quo_r    <= '0;
      rem_r    <= '0;
    end else if (bus.exception) begin
      // Flush: abandon the division but keep the last published results.
      state  <= DIV_IDLE;
      cnt    <= '0;
      done_r <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (bus.start) begin
            dvd_sh   <= abs_dvd_c;
            dvs_mag  <= abs_dvs_c;
            rem_q    <= '0;
            orig_dvd <= bus.dividend;
            quo_neg  <= bus.signed_div & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            rem_neg  <= bus.signed_div & bus.dividend[WIDTH-1];
            div_zero <= (bus.divisor == '0);
            cnt      <= '0;
`ifdef DIV_EARLY_OUT_EN
            if (early_c) begin
              state  <= DIV_DONE;
              done_r <= 1'b1;
              quo_r  <= (bus.divisor == '0) ? '1 : '0;
              rem_r  <= bus.dividend;
            end else begin
              state <= DIV_CALC;
            end
`else
            state <= DIV_CALC;
`endif
          end
        end
        DIV_CALC: begin
          dvd_sh <= quo_nxt_c;
          rem_q  <= rem_nxt_c;
          if (cnt == CNT_LAST) begin
            state  <= DIV_DONE;
            cnt    <= '0;
            done_r <= 1'b1;
            quo_r  <= fix_quo_c;
            rem_r  <= fix_rem_c;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DIV_DONE: begin
          // start is ignored here so the same instruction is never re-issued.
          if (bus.accept) begin
            state  <= DIV_IDLE;
            done_r <= 1'b0;
          end
        end
        default: begin
          state  <= DIV_IDLE;
          cnt    <= '0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_divider.sv
// tb_ex_divider: directed self-checking bench for ex_divider.
// Honours DIV_EARLY_OUT_EN for the short-latency cases.
module tb_ex_divider;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_divider_if bus ();

  ex_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  localparam int LAT_FULL = 33;
`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_SHORT = 1;
`else
  localparam int LAT_SHORT = 33;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Launch at cycle T, check stall/latency/results, then accept.
  task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input int lat);
    int   cyc;
    logic stall_ok;
    bus.start      = 1'b1;
    bus.signed_div = sd;
    bus.dividend   = a;
    bus.divisor    = b;
    bus.accept     = 1'b0;
    #1;
    chk({tag, ":stall_at_T"}, 32'(bus.stall_req), 32'd1);
    tick();
    // Operands must have been captured at launch.
    bus.start    = 1'b0;
    bus.dividend = ~a;
    bus.divisor  = ~b;
    cyc      = 1;
    stall_ok = 1'b1;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (bus.stall_req !== 1'b1) stall_ok = 1'b0;
      tick();
      cyc++;
    end
    chk({tag, ":latency"}, 32'(cyc), 32'(lat));
    chk({tag, ":stall_while_calc"}, 32'(stall_ok), 32'd1);
    chk({tag, ":stall_at_done"}, 32'(bus.stall_req), 32'd0);
    chk({tag, ":q"}, bus.quotient, eq);
    chk({tag, ":r"}, bus.remainder, er);
    bus.accept = 1'b1;
    tick();
    bus.accept = 1'b0;
    chk({tag, ":done_after_accept"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic seen_done;

    // Reset, with start asserted to show stall_req is forced low.
    rst            = 1'b1;
    bus.exception  = 1'b0;
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.dividend   = 32'd100;
    bus.divisor    = 32'd7;
    bus.accept     = 1'b0;
    tick();
    tick();
    chk("rst:stall_forced_low", 32'(bus.stall_req), 32'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    tick();
    chk("rst:done", 32'(bus.done), 32'd0);
    chk("rst:q", bus.quotient, 32'd0);
    chk("rst:r", bus.remainder, 32'd0);
    chk("rst:stall", 32'(bus.stall_req), 32'd0);

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, LAT_FULL);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT_FULL);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, LAT_FULL);
    run_div("divu_by0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, LAT_SHORT);
    run_div("div_by0", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, LAT_SHORT);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, LAT_FULL);

    // Exception beats start in IDLE.
    bus.start      = 1'b1;
    bus.exception  = 1'b1;
    bus.signed_div = 1'b0;
    bus.dividend   = 32'd50;
    bus.divisor    = 32'd5;
    #1;
    chk("exc_idle:stall", 32'(bus.stall_req), 32'd0);
    tick();
    bus.start     = 1'b0;
    bus.exception = 1'b0;
    #1;
    chk("exc_idle:no_launch", 32'(bus.stall_req), 32'd0);

    // Exception on the 10th CALC cycle.
    bus.start    = 1'b1;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.exception = 1'b1;
    tick();
    bus.exception = 1'b0;
    chk("exc_calc:stall", 32'(bus.stall_req), 32'd0);
    chk("exc_calc:done", 32'(bus.done), 32'd0);
    chk("exc_calc:q_kept", bus.quotient, 32'h8000_0000);
    chk("exc_calc:r_kept", bus.remainder, 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      if (bus.done === 1'b1 || bus.stall_req === 1'b1) seen_done = 1'b1;
      tick();
    end
    chk("exc_calc:no_done_pulse", 32'(seen_done), 32'd0);

    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, LAT_FULL);
    run_div("divu_wide", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, LAT_FULL);

    // Reset mid-CALC clears every output.
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.dividend   = 32'd1000;
    bus.divisor    = 32'd3;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("rst_calc:stall_forced_low", 32'(bus.stall_req), 32'd0);
    tick();
    rst = 1'b0;
    chk("rst_calc:q", bus.quotient, 32'd0);
    chk("rst_calc:r", bus.remainder, 32'd0);
    chk("rst_calc:done", 32'(bus.done), 32'd0);

    // Hold in DONE with accept=0 and start=1.
    bus.start    = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    bus.accept   = 1'b0;
    tick();
    bus.start = 1'b0;
    begin
      int cyc;
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < 40) begin
        tick();
        cyc++;
      end
      chk("hold:latency", 32'(cyc), 32'(LAT_FULL));
    end
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold%0d:done", i), 32'(bus.done), 32'd1);
      chk($sformatf("hold%0d:q", i), bus.quotient, 32'd14);
      chk($sformatf("hold%0d:r", i), bus.remainder, 32'd2);
      chk($sformatf("hold%0d:stall", i), 32'(bus.stall_req), 32'd0);
      tick();
    end
    bus.start  = 1'b0;
    bus.accept = 1'b1;
    tick();
    bus.accept = 1'b0;
    chk("hold:released", 32'(bus.done), 32'd0);
    chk("hold:no_relaunch", 32'(bus.stall_req), 32'd0);

    run_div("divu_5_9", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, LAT_SHORT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
